// File: rtl/port_sram_match_engine.sv
// ---------------------------------------------------------------------------
// port_sram_match_engine
//
// Picks an SRAM to take a packet of new_length pages headed to new_dest_port.
// An external scanner presents one SRAM's status per cycle (scan_sram,
// free_space, accessible, packet_amount). While a request is active the engine
// evaluates each presented SRAM and selects one according to match_mode.
//
// Handshake: match_enable is a level request. The requester raises it and
// holds it until match_state reads MATCHED (match_suc pulses once on that
// transition), then drops it to return the engine to IDLE. Dropping it while
// still MATCHING or OVERTIME aborts the request with no side effects.
//
// Ports
//   clk                 single clock
//   rst_n               asynchronous active-low reset
//   match_mode[1:0]     0 first fit, 1/3 best by amount then space, 2 best by space
//   match_threshold     evaluation window length (0 treated as 1)
//   match_enable        request level
//   viscous             prefer the previously matched SRAM when it qualifies
//   new_dest_port       destination port of the request (latched)
//   new_length          page count of the request (latched)
//   scan_sram           SRAM index whose status is presented this cycle
//   free_space          free pages of scan_sram
//   accessible          scan_sram may be written
//   packet_amount       queued packets of the latched port in scan_sram
//   match_state[1:0]    0 IDLE, 1 MATCHING, 2 MATCHED, 3 OVERTIME
//   match_suc           one-cycle pulse on entering MATCHED
//   matching_best_sram  selected SRAM index, only updated on entering MATCHED
// ---------------------------------------------------------------------------
module port_sram_match_engine #(
    parameter int SRAM_NUM = 32,
    parameter int IDX_W    = 5,
    parameter int PORT_W   = 4,
    parameter int LEN_W    = 9,
    parameter int SPACE_W  = 11,
    parameter int AMT_W    = 9,
    parameter int THR_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         match_mode,
    input  logic [THR_W-1:0]   match_threshold,
    input  logic               match_enable,
    input  logic               viscous,
    input  logic [PORT_W-1:0]  new_dest_port,
    input  logic [LEN_W-1:0]   new_length,
    input  logic [IDX_W-1:0]   scan_sram,
    input  logic [SPACE_W-1:0] free_space,
    input  logic               accessible,
    input  logic [AMT_W-1:0]   packet_amount,
    output logic [1:0]         match_state,
    output logic               match_suc,
    output logic [IDX_W-1:0]   matching_best_sram
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MATCHING = 2'd1,
        ST_MATCHED  = 2'd2,
        ST_OVERTIME = 2'd3
    } state_e;

    // Free space and length are compared zero-extended to a common width.
    localparam int CMP_W = (SPACE_W > LEN_W) ? SPACE_W : LEN_W;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e             state_q,      state_d;
    logic               suc_q,        suc_d;
    logic [IDX_W-1:0]   best_out_q,   best_out_d;
    logic [THR_W-1:0]   cnt_q,        cnt_d;
    logic               bv_q,         bv_d;       // window best is valid
    logic [IDX_W-1:0]   bidx_q,       bidx_d;     // window best index
    logic [AMT_W-1:0]   bamt_q,       bamt_d;     // window best packet amount
    logic [SPACE_W-1:0] bfree_q,      bfree_d;    // window best free space
    logic               last_valid_q, last_valid_d;
    logic [IDX_W-1:0]   last_sram_q,  last_sram_d;
    logic [PORT_W-1:0]  dest_q,       dest_d;
    logic [LEN_W-1:0]   len_q,        len_d;

    // ------------------------------------------------------------------
    // Per-cycle evaluation helpers
    // ------------------------------------------------------------------
    logic [CMP_W-1:0]   free_ext;
    logic [CMP_W-1:0]   len_ext;
    logic               in_range;
    logic               cand;
    logic               sticky_hit;
    logic [THR_W-1:0]   eff_thr;
    logic [THR_W:0]     cnt_inc;
    logic [THR_W-1:0]   cnt_sat;
    logic               window_end;
    logic               beats_best;
    logic               better;
    logic               take;
    logic [IDX_W-1:0]   take_idx;

    // The destination port is held for the status source, which keys
    // packet_amount on it; nothing inside the engine consumes it.
    logic unused_dest;
    assign unused_dest = ^dest_q;

    assign free_ext = CMP_W'(free_space);
    assign len_ext  = CMP_W'(len_q);

    // Indices past the last SRAM are never selectable.
    assign in_range = ({1'b0, scan_sram} < (IDX_W + 1)'(SRAM_NUM));
    assign cand     = accessible && in_range && (free_ext >= len_ext);

    assign sticky_hit = viscous && last_valid_q && (scan_sram == last_sram_q) && cand;

    assign eff_thr = (match_threshold == '0) ? THR_W'(1) : match_threshold;
    assign cnt_inc = {1'b0, cnt_q} + 1'b1;
    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_inc[THR_W-1:0];
    // cnt_inc counts the current evaluation. Using >= means a threshold
    // lowered below the running count closes the window at once instead of
    // leaving it open until the counter saturates.
    assign window_end = (cnt_inc >= {1'b0, eff_thr});

    always_comb begin
        beats_best = 1'b0;
        if (match_mode == 2'd2) begin
            beats_best = (free_space > bfree_q);
        end else begin
            beats_best = (packet_amount > bamt_q) ||
                         ((packet_amount == bamt_q) && (free_space > bfree_q));
        end
    end

    // A candidate replaces the window best if there is none yet or it
    // strictly beats it; ties keep the earlier SRAM.
    assign better = cand && (!bv_q || beats_best);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        suc_d        = 1'b0;
        best_out_d   = best_out_q;
        cnt_d        = cnt_q;
        bv_d         = bv_q;
        bidx_d       = bidx_q;
        bamt_d       = bamt_q;
        bfree_d      = bfree_q;
        last_valid_d = last_valid_q;
        last_sram_d  = last_sram_q;
        dest_d       = dest_q;
        len_d        = len_q;
        take         = 1'b0;
        take_idx     = scan_sram;

        case (state_q)
            ST_IDLE: begin
                if (match_enable) begin
                    dest_d  = new_dest_port;
                    len_d   = new_length;
                    cnt_d   = '0;
                    bv_d    = 1'b0;
                    state_d = ST_MATCHING;
                end
            end

            ST_MATCHING: begin
                if (!match_enable) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_sat;
                    if (sticky_hit) begin
                        take     = 1'b1;
                        take_idx = scan_sram;
                    end else if (match_mode == 2'd0) begin
                        if (cand) begin
                            take     = 1'b1;
                            take_idx = scan_sram;
                        end else if (window_end) begin
                            state_d = ST_OVERTIME;
                        end
                    end else if (window_end) begin
                        // The closing evaluation still competes with the best.
                        if (better) begin
                            take     = 1'b1;
                            take_idx = scan_sram;
                        end else if (bv_q) begin
                            take     = 1'b1;
                            take_idx = bidx_q;
                        end else begin
                            state_d = ST_OVERTIME;
                        end
                    end else if (better) begin
                        bv_d    = 1'b1;
                        bidx_d  = scan_sram;
                        bamt_d  = packet_amount;
                        bfree_d = free_space;
                    end
                end
            end

            ST_OVERTIME: begin
                if (!match_enable) begin
                    state_d = ST_IDLE;
                end else if (cand) begin
                    take     = 1'b1;
                    take_idx = scan_sram;
                end
            end

            ST_MATCHED: begin
                if (!match_enable) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            state_d      = ST_MATCHED;
            suc_d        = 1'b1;
            best_out_d   = take_idx;
            last_sram_d  = take_idx;
            last_valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            suc_q        <= 1'b0;
            best_out_q   <= '0;
            cnt_q        <= '0;
            bv_q         <= 1'b0;
            bidx_q       <= '0;
            bamt_q       <= '0;
            bfree_q      <= '0;
            last_valid_q <= 1'b0;
            last_sram_q  <= '0;
            dest_q       <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            suc_q        <= suc_d;
            best_out_q   <= best_out_d;
            cnt_q        <= cnt_d;
            bv_q         <= bv_d;
            bidx_q       <= bidx_d;
            bamt_q       <= bamt_d;
            bfree_q      <= bfree_d;
            last_valid_q <= last_valid_d;
            last_sram_q  <= last_sram_d;
            dest_q       <= dest_d;
            len_q        <= len_d;
        end
    end

    assign match_state        = state_q;
    assign match_suc          = suc_q;
    assign matching_best_sram = best_out_q;

endmodule

// File: doc/port_sram_match_engine.md
PORT_SRAM_MATCH_ENGINE -- requirements
Module: port_sram_match_engine
Interface
REQ-001 SHALL have parameter SRAM_NUM, default 32, the number of SRAMs scanned.
REQ-002 SHALL have parameter IDX_W, default 5, the SRAM index width, equal to clog2(SRAM_NUM).
REQ-003 SHALL have parameter PORT_W, default 4, the destination port width.
REQ-004 SHALL have parameter LEN_W, default 9, the packet length width in pages.
REQ-005 SHALL have parameter SPACE_W, default 11, the free-space width.
REQ-006 SHALL have parameter AMT_W, default 9, the packet-amount width.
REQ-007 SHALL have parameter THR_W, default 5, the threshold width.
REQ-008 SHALL have ports, each as name, direction, width, meaning:
- clk, in, 1, the single clock.
- rst_n, in, 1, asynchronous active-low reset.
- match_mode, in, 2, selection policy (REQ-014).
- match_threshold, in, THR_W, evaluation window length in cycles.
- match_enable, in, 1, request level; held high until MATCHED is seen.
- viscous, in, 1, prefer the previously matched SRAM.
- new_dest_port, in, PORT_W, destination port of the request.
- new_length, in, LEN_W, page count of the request.
- scan_sram, in, IDX_W, SRAM whose status is presented this cycle.
- free_space, in, SPACE_W, free pages of scan_sram.
- accessible, in, 1, scan_sram may be written.
- packet_amount, in, AMT_W, number of queued packets of the latched dest port in scan_sram.
- match_state, out, 2, 0=IDLE, 1=MATCHING, 2=MATCHED, 3=OVERTIME.
- match_suc, out, 1, one-cycle success pulse.
- matching_best_sram, out, IDX_W, selected SRAM index.
Function
REQ-009 SHALL latch new_dest_port and new_length on the edge where state=IDLE and match_enable=1, clear the eval counter and best_valid, and enter MATCHING.
REQ-010 SHALL treat a cycle in MATCHING or OVERTIME as a candidate iff accessible=1 and zero-extended free_space >= zero-extended latched length.
REQ-011 SHALL perform one evaluation per MATCHING cycle, using the status inputs of that same cycle, with the result registered at the next edge.
REQ-012 SHALL keep the eval counter saturating at 2^THR_W-1.
REQ-013 SHALL use an effective threshold of max(match_threshold, 1).
REQ-014 SHALL apply these modes:
- Mode 0: first fit; the first candidate wins immediately.
- Mode 1: window best; a candidate with greater packet_amount replaces the best; on equal packet_amount, greater free_space replaces it; remaining ties keep the earlier one.
- Mode 2: window best by free_space only, strictly greater replaces.
- Mode 3: behaves as mode 1.
REQ-015 SHALL, in modes 1-3, end the window at the evaluation whose count (including the current one) equals the effective threshold; that evaluation's candidate participates.
REQ-016 SHALL go MATCHING->MATCHED at window end if best_valid, or if the current cycle holds a candidate.
REQ-017 SHALL go MATCHING->OVERTIME at window end if there is no candidate.
REQ-018 SHALL, in OVERTIME, take the first candidate and go to MATCHED.
REQ-019 SHALL, when viscous=1, last_valid=1 and scan_sram=last_sram is a candidate in MATCHING or OVERTIME, go to MATCHED with that SRAM in that cycle, in any mode, overriding a different window best.
REQ-020 SHALL, on entering MATCHED: register matching_best_sram, pulse match_suc for exactly one cycle, set last_sram to the chosen index, and set last_valid=1.
REQ-021 SHALL hold MATCHED while match_enable=1 and go MATCHED->IDLE on match_enable=0.
REQ-022 SHALL keep matching_best_sram stable outside the transition into MATCHED.
REQ-023 SHALL treat match_enable=0 in MATCHING or OVERTIME as an abort: go to IDLE, no match_suc, and last_sram, last_valid and matching_best_sram are unchanged.
REQ-024 SHALL ignore changes to match_mode, match_threshold and viscous except at evaluation edges; the mode is sampled per evaluation.
REQ-025 SHALL have a minimum latency of 2 edges from the enable sample to match_suc (mode 0, candidate in the first MATCHING cycle).
Reset
REQ-026 SHALL, on rst_n=0, immediately and asynchronously set: match_state=0, match_suc=0, matching_best_sram=0, counter=0, best_valid=0, last_valid=0, last_sram=0.
REQ-027 SHALL, if reset is applied mid-operation, discard the request; after release, a new match_enable edge is required.
Verification
REQ-028 SHALL verify mode 0: length 1; scan_sram 7 accessible with free 5 in the first MATCHING cycle -> match_suc 2 edges after enable, best=7, state=2.
REQ-029 SHALL verify mode 1 with threshold 3: candidates (sram, amt, free) = (4,2,10), (9,5,3), (12,5,8) -> MATCHED after 3 evaluations, best=12.
REQ-030 SHALL verify threshold 2 with length 20 and all free_space<=19 -> state 3; the next accessible SRAM 21 with free 40 -> best=21 with a single match_suc.
REQ-031 SHALL verify viscous=1 with last_sram=6 in mode 2 and threshold 15: the first evaluation is (3, free 100) and the third is (6, free 2), length 1 -> MATCHED on the third evaluation, best=6.
REQ-032 SHALL verify that dropping match_enable in evaluation 2 -> IDLE with no match_suc and best unchanged; then a new request succeeds normally.
REQ-033 SHALL verify rst_n low mid-MATCHING (asynchronous, between edges) -> all outputs 0 immediately; threshold 0 in mode 1 behaves as 1.
